usb_trans_sched: RTL
====================

# usb_trans_sched

Transaction scheduler sitting in front of the USB host protocol FSM. It arbitrates round-robin between NREQ host-side requesters. For each grant it issues a single IN or OUT transaction to the protocol FSM and retries on reported failure up to MAX_RETRY times. It enforces a watchdog and returns completion status, and IN data, to the granted requester.

## Interface
- NREQ, 2: number of requesters (2..8).
- MAX_RETRY, 2: re-issues allowed after a `failure` (0..7).
- WDOG_CYCLES, 32768: cycles in WAIT before abandoning a transaction (≤ 65535).
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until own `done`.
- req_is_in  in  NREQ  1 = IN transaction, 0 = OUT; sampled at grant.
- req_wdata  in  NREQ×64  OUT payload (packed [NREQ-1:0][63:0]); sampled at grant.
- gnt  out  NREQ  one-hot grant, high ISSUE through WAIT.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  NREQ  one-cycle pulse coincident with `done` on failure or watchdog.
- rdata  out  64  IN data; valid while `done` is high for a successful IN; otherwise holds its last value.
- busy  out  1  high in any state except IDLE.
- wdog_trip  out  1  sticky; set on watchdog expiry; cleared only by reset.
- in_trans  out  1  one-cycle pulse to the protocol FSM.
- out_trans  out  1  one-cycle pulse to the protocol FSM.
- data_from_host  out  64  OUT payload to the protocol FSM; stable from ISSUE through DONE.
- success  in  1  protocol FSM one-cycle success pulse.
- failure  in  1  protocol FSM one-cycle failure pulse.
- data_to_host  in  64  protocol FSM IN data; valid with `success`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE
  - If any `req` is high, select the winner by round-robin, searching from `ptr` upward with wrap.
  - Latch the index, `req_is_in` and `req_wdata` for the winner.
  - Set `gnt`, set `in_trans` or `out_trans`, clear the retry count, go to ISSUE.
  - `ptr` <= winner+1, wrapping to 0 after NREQ-1.
- ISSUE
  - Drop `in_trans`/`out_trans`; clear the watchdog counter; go to WAIT.
- WAIT (watchdog counter increments each cycle)
  - `failure` high (including when `success` is high in the same cycle):
    - retry count < MAX_RETRY: increment the retry count, re-pulse the same transaction type, go to ISSUE.
    - otherwise: set `done` and `err` for the index, go to DONE.
  - `success` high alone: set `done` for the index; if IN, `rdata` <= `data_to_host`; go to DONE.
  - Counter reaches WDOG_CYCLES-1 with neither pulse: set `done`, `err` and `wdog_trip`, go to DONE. No retry after a watchdog expiry.
  - `success`/`failure` are ignored in every state except WAIT.
- DONE
  - Lasts one cycle; `done`/`err` are high and `gnt` is low.
  - `req` is not sampled in DONE; the requester drops `req` at this edge.
  - Go to IDLE.
- Reset: state IDLE, `ptr`=0, counters 0, every output 0 (including `rdata`, `data_from_host` and `wdog_trip`).
  - A reset mid-transaction simply abandons the transaction; no `done` is produced.

## Timing
- `req` seen in IDLE at edge t: `gnt` and `in_trans`/`out_trans` are high during cycle t+1, and the strobe lasts exactly one cycle.
- Pulse sampled in WAIT at edge t: `done`/`err` are high during cycle t+1 (DONE); IDLE begins at cycle t+2.
- Minimum spacing between two grants is 4 cycles plus the protocol FSM latency.
- Retry path: `failure` sampled at edge t, re-strobe high in cycle t+1. The protocol FSM is already in Hold, so no spacer cycle is needed.
- Watchdog counter is 16 bits; it does not wrap within WAIT.

## Structure
- Shared package `usb_ctrl_pkg` holds:
  - the scheduler state enum;
  - the 64-bit data type;
  - the index width function for NREQ.
- One sub-module, `rr_arbiter`: combinational round-robin picker.
  - Inputs: `req` vector, `ptr`.
  - Outputs: one-hot winner, binary index, `any_req`.
  - The top module holds `ptr`.

## Test plan
- Single IN, NREQ=2: `req`=01 with `req_is_in`=1; bench returns `success` with `data_to_host`=64'hDEADBEEF_00C0FFEE 40 cycles after the strobe. Required: one `in_trans` pulse; `done`=01, `err`=00, `rdata`=DEADBEEF_00C0FFEE.
- OUT with retries, MAX_RETRY=2: OUT with `req_wdata`=64'h1234; bench returns `failure`, `failure`, `success`. Required: 3 `out_trans` pulses; `data_from_host`=64'h1234 throughout; final `done`, no `err`.
- Retry exhaustion: 3 consecutive `failure` pulses. Required: 3 strobes, then `done`+`err` for the index; no 4th strobe.
- Round-robin fairness: `req`=11 held continuously, each transaction succeeding. Required: grants alternate 01, 10, 01, 10; `ptr` wraps.
- Watchdog and reset, WDOG_CYCLES=100: no response from the bench. Required: `done`+`err` 101 cycles after the strobe and `wdog_trip`=1. Then assert `rst` mid-WAIT on the next transaction: all outputs read 0 and there is no `done`.

Source files
------------

// File: rtl/usb_ctrl_pkg.sv
// Shared types for the USB host controller slice: scheduler states,
// the 64-bit data word, and the requester index width helper.
package usb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sched_state_t;

  typedef logic [63:0] data64_t;

  // A single requester still needs a 1-bit index so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request found
// searching upward from ptr, wrapping past NREQ-1 back to 0.
module rr_arbiter
  import usb_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any_req
);

  logic [IW-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!any_req && req[cand]) begin
        any_req       = 1'b1;
        win_idx       = cand;
        win_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_trans_sched.sv
// Transaction scheduler in front of the USB host protocol FSM: grants one
// requester at a time, issues IN/OUT, retries on failure, and watchdogs WAIT.
module usb_trans_sched
  import usb_ctrl_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int MAX_RETRY   = 2,
  parameter int WDOG_CYCLES = 32768,
  localparam int IW = idx_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_is_in,
  input  logic [NREQ-1:0][63:0] req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err,
  output data64_t               rdata,
  output logic                  busy,
  output logic                  wdog_trip,
  output logic                  in_trans,
  output logic                  out_trans,
  output data64_t               data_from_host,
  input  logic                  success,
  input  logic                  failure,
  input  data64_t               data_to_host
);

  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

  sched_state_t    state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic            is_in, is_in_n;
  logic [2:0]      retry_cnt, retry_n;
  logic [15:0]     wdog_cnt, wdog_n;
  logic [NREQ-1:0] gnt_n, done_n, err_n;
  data64_t         rdata_n, dfh_n;
  logic            trip_n, in_n, out_n, busy_n;

  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            any_req;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    is_in_n = is_in;
    retry_n = retry_cnt;
    wdog_n  = wdog_cnt;
    gnt_n   = gnt;
    done_n  = '0;
    err_n   = '0;
    rdata_n = rdata;
    dfh_n   = data_from_host;
    trip_n  = wdog_trip;
    in_n    = 1'b0;
    out_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          is_in_n = req_is_in[win_idx];
          dfh_n   = req_wdata[win_idx];
          gnt_n   = win_oh;
          in_n    = req_is_in[win_idx];
          out_n   = !req_is_in[win_idx];
          retry_n = '0;
          ptr_n   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_n  = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_n = wdog_cnt + 16'd1;
        // failure wins over a coincident success pulse
        if (failure) begin
          if (retry_cnt < 3'(MAX_RETRY)) begin
            retry_n = retry_cnt + 3'd1;
            in_n    = is_in;
            out_n   = !is_in;
            state_n = ST_ISSUE;
          end else begin
            done_n  = gnt;
            err_n   = gnt;
            gnt_n   = '0;
            state_n = ST_DONE;
          end
        end else if (success) begin
          done_n = gnt;
          if (is_in) rdata_n = data_to_host;
          gnt_n   = '0;
          state_n = ST_DONE;
        end else if (wdog_cnt == WDOG_LAST) begin
          done_n  = gnt;
          err_n   = gnt;
          trip_n  = 1'b1;
          gnt_n   = '0;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      is_in          <= 1'b0;
      retry_cnt      <= '0;
      wdog_cnt       <= '0;
      gnt            <= '0;
      done           <= '0;
      err            <= '0;
      rdata          <= '0;
      data_from_host <= '0;
      wdog_trip      <= 1'b0;
      in_trans       <= 1'b0;
      out_trans      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      ptr            <= ptr_n;
      is_in          <= is_in_n;
      retry_cnt      <= retry_n;
      wdog_cnt       <= wdog_n;
      gnt            <= gnt_n;
      done           <= done_n;
      err            <= err_n;
      rdata          <= rdata_n;
      data_from_host <= dfh_n;
      wdog_trip      <= trip_n;
      in_trans       <= in_n;
      out_trans      <= out_n;
      busy           <= busy_n;
    end
  end

endmodule
